// File: rtl/console_usb_pkg.sv
// rtl/console_usb_pkg.sv - shared constants, state encoding and btype codes for the console USB poller
package console_usb_pkg;

    localparam int NUM_CH_DEF  = 8;
    localparam int BTW_DEF     = 4;
    localparam int TIMEOUT_DEF = 50000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_SEND = 3'd2,
        ST_READ = 3'd3,
        ST_ACK  = 3'd4,
        ST_DONE = 3'd5
    } poll_state_e;

    // btype codes understood by the branch/HQ side of the link
    localparam logic [BTW_DEF-1:0] BTYPE_NULL   = 4'h0;
    localparam logic [BTW_DEF-1:0] BTYPE_STATUS = 4'h1;
    localparam logic [BTW_DEF-1:0] BTYPE_CONFIG = 4'h2;
    localparam logic [BTW_DEF-1:0] BTYPE_DATA   = 4'h3;

endpackage

// File: rtl/console_usb_wdog.sv
// rtl/console_usb_wdog.sv - per-channel watchdog counter for the poll sequencer
module console_usb_wdog
    import console_usb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is only meaningful while the owner is waiting on a channel
    assign expire_o = en_i && (cnt_q == LAST);

    // Count enabled cycles, saturating at the expiry value until cleared
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/console_usb_poll.sv
// rtl/console_usb_poll.sv - round-robin poll sequencer over the console USB channel links
module console_usb_poll
    import console_usb_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int BTW     = BTW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fs_poll,
    output logic                    fd_poll,
    input  logic [0:NUM_CH-1]       ch_mask,
    input  logic [BTW-1:0]          poll_btype,
    output logic [0:NUM_CH-1]       fs_usb_send,
    input  logic [0:NUM_CH-1]       fd_usb_send,
    output logic [0:NUM_CH*BTW-1]   send_usb_btype,
    input  logic [0:NUM_CH-1]       fs_usb_read,
    output logic [0:NUM_CH-1]       fd_usb_read,
    input  logic [0:NUM_CH*BTW-1]   read_usb_btype,
    output logic [0:NUM_CH-1]       ch_stat,
    output logic [0:NUM_CH*BTW-1]   rx_btype
);

    localparam int IW  = $clog2(NUM_CH + 1);
    localparam int CIW = $clog2(NUM_CH);
    localparam int BW  = $clog2(NUM_CH * BTW);

    poll_state_e              state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [0:NUM_CH-1]        mask_q, mask_d;
    logic [BTW-1:0]           btype_q, btype_d;
    logic                     poll_q;
    logic                     fd_poll_q, fd_poll_d;
    logic [0:NUM_CH-1]        fs_send_q, fs_send_d;
    logic [0:NUM_CH*BTW-1]    send_btype_q, send_btype_d;
    logic [0:NUM_CH-1]        fd_read_q, fd_read_d;
    logic [0:NUM_CH-1]        ch_stat_q, ch_stat_d;
    logic [0:NUM_CH*BTW-1]    rx_btype_q, rx_btype_d;
    logic                     wd_clr, wd_en, wd_exp;
    logic [CIW-1:0]           cur;
    logic [BW-1:0]            base;

    assign cur  = idx_q[CIW-1:0];
    assign base = BW'(cur) * BW'(BTW);

    console_usb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_exp)
    );

    // Sequencer: walk the latched mask, run the send/read/ack handshake on the current channel
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        btype_d      = btype_q;
        fd_poll_d    = fd_poll_q;
        fs_send_d    = fs_send_q;
        send_btype_d = send_btype_q;
        fd_read_d    = fd_read_q;
        ch_stat_d    = ch_stat_q;
        rx_btype_d   = rx_btype_q;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (poll_q) begin
                    mask_d    = ch_mask;
                    btype_d   = poll_btype;
                    idx_d     = '0;
                    ch_stat_d = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_q == IW'(NUM_CH)) begin
                    fd_poll_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (!mask_q[cur]) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    fs_send_d[cur]             = 1'b1;
                    send_btype_d[base +: BTW]  = btype_q;
                    wd_clr                     = 1'b1;
                    state_d                    = ST_SEND;
                end
            end
            ST_SEND: begin
                wd_en = 1'b1;
                if (wd_exp) begin
                    fs_send_d[cur] = 1'b0;
                    ch_stat_d[cur] = 1'b0;
                    idx_d          = idx_q + 1'b1;
                    state_d        = ST_SCAN;
                end else if (fd_usb_send[cur]) begin
                    fs_send_d[cur] = 1'b0;
                    state_d        = ST_READ;
                end
            end
            ST_READ: begin
                wd_en = 1'b1;
                if (wd_exp) begin
                    ch_stat_d[cur] = 1'b0;
                    idx_d          = idx_q + 1'b1;
                    state_d        = ST_SCAN;
                end else if (fs_usb_read[cur]) begin
                    rx_btype_d[base +: BTW] = read_usb_btype[base +: BTW];
                    fd_read_d[cur]          = 1'b1;
                    state_d                 = ST_ACK;
                end
            end
            ST_ACK: begin
                wd_en = 1'b1;
                // Data was already captured, so a stuck ack still counts as a completed channel
                if (wd_exp || !fs_usb_read[cur]) begin
                    fd_read_d[cur] = 1'b0;
                    ch_stat_d[cur] = 1'b1;
                    idx_d          = idx_q + 1'b1;
                    state_d        = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (!poll_q) begin
                    fd_poll_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and registered-output update; fs_poll is registered before use
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            mask_q       <= '0;
            btype_q      <= '0;
            poll_q       <= 1'b0;
            fd_poll_q    <= 1'b0;
            fs_send_q    <= '0;
            send_btype_q <= '0;
            fd_read_q    <= '0;
            ch_stat_q    <= '0;
            rx_btype_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            btype_q      <= btype_d;
            poll_q       <= fs_poll;
            fd_poll_q    <= fd_poll_d;
            fs_send_q    <= fs_send_d;
            send_btype_q <= send_btype_d;
            fd_read_q    <= fd_read_d;
            ch_stat_q    <= ch_stat_d;
            rx_btype_q   <= rx_btype_d;
        end
    end

    assign fd_poll        = fd_poll_q;
    assign fs_usb_send    = fs_send_q;
    assign send_usb_btype = send_btype_q;
    assign fd_usb_read    = fd_read_q;
    assign ch_stat        = ch_stat_q;
    assign rx_btype       = rx_btype_q;

endmodule
